mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the memory byte-port width; only 8 is supported.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_done.
REQ-006 if_addr  input  ADDR_WIDTH  fetch byte address, held stable while if_req is high.
REQ-007 if_rdata  output  32  fetched word, little-endian.
REQ-008 if_done  output  1  one-cycle completion pulse.
REQ-009 if_err  output  1  misaligned fetch, valid with if_done.
REQ-010 d_req  input  1  load/store request, held high until d_done.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-013 d_addr  input  ADDR_WIDTH  load/store byte address.
REQ-014 d_wdata  input  32  store data; low bytes are used first.
REQ-015 d_rdata  output  32  load data, zero-extended.
REQ-016 d_done  output  1  one-cycle completion pulse.
REQ-017 d_err  output  1  misaligned or illegal-size access, valid with d_done.
REQ-018 mem_addr  output  ADDR_WIDTH  byte address to the memory.
REQ-019 mem_wdata  output  DATA_WIDTH  write byte to the memory.
REQ-020 mem_we  output  1  memory write enable; the memory writes on the clk edge.
REQ-021 mem_rdata  input  DATA_WIDTH  memory read byte, valid combinationally in the same cycle as mem_addr.
REQ-022 busy  output  1  high whenever the state is not IDLE.

Function
REQ-023 SHALL implement the FSM states IDLE, XFER and RESP.
REQ-024 In IDLE with a request pending, SHALL record the grant, latch the byte count (1, 2 or 4; 4 for fetch) and move to XFER.
  - If the request is misaligned or d_size=11, SHALL move directly to RESP with the error flag set.
REQ-025 Arbitration: if only one requester is pending, SHALL grant it.
  - If both are pending, SHALL grant round-robin against a last_grant register.
  - last_grant resets to "fetch", so data wins the first tie.
REQ-026 Alignment rules SHALL be:
  - half access: addr[0] must be 0;
  - word access and fetch: addr[1:0] must be 00;
  - byte access: always aligned.
REQ-027 In XFER, SHALL run one byte per cycle with cnt = 0..N-1 and mem_addr = base + cnt.
  - Read: SHALL capture mem_rdata into byte lane cnt of the assembly register.
  - Write: SHALL drive mem_we=1 and mem_wdata = d_wdata[8*cnt+7:8*cnt].
REQ-028 After byte N-1, SHALL move to RESP.
  - In RESP, SHALL pulse the granted done for exactly one cycle with rdata and err valid, then return to IDLE.
REQ-029 Latency: with the request sampled in IDLE at cycle 0, bytes SHALL occupy cycles 1..N and done SHALL assert in cycle N+1.
  - Errored requests SHALL assert done in cycle 1.
REQ-030 Requesters drop req in the done cycle; req SHALL be re-sampled only in IDLE, so there is one idle cycle between back-to-back transactions.
REQ-031 Outside XFER, SHALL hold mem_we=0, mem_addr=0 and mem_wdata=0.
  - An errored request SHALL never assert mem_we.
REQ-032 Unused upper bytes of d_rdata SHALL be 0, and stores SHALL leave d_rdata=0.
REQ-033 if_rdata and d_rdata SHALL hold their values until the next completion for the same port.
REQ-034 Requests arriving during XFER or RESP SHALL wait; they are never dropped while held high.

Reset
REQ-035 With rst_n low at a clk edge, SHALL clear to: state=IDLE, cnt=0, last_grant=fetch; all done, err, rdata and mem_* outputs 0; busy=0.
REQ-036 Reset mid-XFER SHALL abort with no done pulse.
  - Bytes already written stay written; no further write occurs after the reset edge.

Verification
REQ-037 Word store: d_req, d_we=1, d_size=10, d_addr=0x10, d_wdata=0xAABBCCDD -> writes DD, CC, BB, AA to 0x10..0x13 in cycles 1-4, d_done in cycle 5, d_err=0.
REQ-038 Fetch: if_req, if_addr=0x10 over the memory from REQ-037 -> if_rdata=0xAABBCCDD, if_done in cycle 5.
REQ-039 Simultaneous requests: if_req and d_req (byte load, addr 0x11) rise together after reset -> data served first (d_rdata=0x000000CC, d_done in cycle 2), fetch granted in the next IDLE.
REQ-040 Misaligned/illegal: d_size=10 with d_addr=0x12, then d_size=11 -> d_done and d_err=1 in cycle 1, mem_we never high; if_addr=0x3 -> if_err=1.
REQ-041 Half load at 0x12 -> d_rdata=0x0000AABB; a byte store at 0x13 with d_wdata=0x11 changes only that byte.
REQ-042 Reset after byte 2 of a word store -> no d_done, busy=0 next cycle, bytes 0-1 written, bytes 2-3 unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and load/store requests onto a byte-wide memory port
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_done,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    gnt_d;
    logic                    we_q;
    logic [1:0]              cnt;
    logic [1:0]              last_idx;
    logic [ADDR_WIDTH-1:0]   base;
    logic [31:0]             wdata_q;
    logic [31:0]             asm_q;
    logic [31:0]             asm_next;
    logic                    pick_d;
    logic                    req_err;
    logic [1:0]              size_idx;

    // Data wins unless fetch is also pending and data had the previous grant.
    assign pick_d   = d_req && (!if_req || !last_grant);
    assign size_idx = d_size == 2'b00 ? 2'd0 : d_size == 2'b01 ? 2'd1 : 2'd3;
    assign req_err  = pick_d ? (d_size == 2'b11 || (d_size == 2'b01 && d_addr[0]) ||
                                (d_size == 2'b10 && d_addr[1:0] != 2'b00))
                             : if_addr[1:0] != 2'b00;

    assign busy      = state != IDLE;
    assign mem_we    = state == XFER && we_q;
    assign mem_addr  = state == XFER ? base + ADDR_WIDTH'(cnt) : '0;
    assign mem_wdata = mem_we ? wdata_q[{cnt, 3'b000} +: 8] : '0;

    // Assembly register with the current read byte merged into lane cnt.
    always_comb begin
        asm_next = asm_q;
        if (!we_q) asm_next[{cnt, 3'b000} +: 8] = mem_rdata;
    end

    // Arbitration FSM: grant in IDLE, one byte per cycle in XFER, done pulse in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            gnt_d      <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= 2'd0;
            last_idx   <= 2'd0;
            base       <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: if (if_req || d_req) begin
                    gnt_d      <= pick_d;
                    last_grant <= pick_d;
                    base       <= pick_d ? d_addr : if_addr;
                    we_q       <= pick_d && d_we;
                    wdata_q    <= d_wdata;
                    last_idx   <= pick_d ? size_idx : 2'd3;
                    cnt        <= 2'd0;
                    asm_q      <= '0;
                    if (req_err) begin
                        state <= RESP;
                        if (pick_d) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    asm_q <= asm_next;
                    cnt   <= cnt + 2'd1;
                    if (cnt == last_idx) begin
                        state <= RESP;
                        cnt   <= 2'd0;
                        if (gnt_d) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= asm_next;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= 1'b0;
                            if_rdata <= asm_next;
                        end
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
